// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for up to eight active-low
// common-anode 7-segment digits. Each rising edge of display_Freq advances
// one digit; every digit is preceded by a blanking gap of all anodes off.
// The displayed value, enables and decimal points are snapshotted once per
// frame at the start of digit 0's blanking gap.
//
// display_Freq is a level input sampled every Sys_Clk; a rising edge is only
// honoured while a digit is being shown. Edges landing in a blanking gap are
// dropped. All outputs are registered, so they trail the scan state by one
// Sys_Clk.
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 8,
  parameter int BLANK_CYCLES = 16,
  parameter bit LZ_BLANK     = 1'b0
) (
  input  logic        Sys_Clk,
  input  logic        rst_n,
  input  logic        display_Freq,
  input  logic [31:0] data,
  input  logic [7:0]  digit_en,
  input  logic [7:0]  dp_en,
  output logic [7:0]  AN,
  output logic [6:0]  SEG,
  output logic        DP,
  output logic        frame_done
);

  localparam int             CW         = $clog2(BLANK_CYCLES + 1);
  localparam logic [2:0]     LAST_IDX   = 3'(NUM_DIGITS - 1);
  localparam logic [CW-1:0]  BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t        state, state_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [CW-1:0] blank_cnt, blank_cnt_nxt;
  logic          df_q, tick;
  logic [31:0]   snap_data;
  logic [7:0]    snap_en, snap_dp;
  logic          snap_load;
  logic [3:0]    nibble;
  logic          suppress;
  logic [7:0]    an_nxt;
  logic [6:0]    seg_nxt;
  logic          dp_nxt, fd_nxt;

  // Active-low hex font, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'h0: seg_decode = 7'h40;
      4'h1: seg_decode = 7'h79;
      4'h2: seg_decode = 7'h24;
      4'h3: seg_decode = 7'h30;
      4'h4: seg_decode = 7'h19;
      4'h5: seg_decode = 7'h12;
      4'h6: seg_decode = 7'h02;
      4'h7: seg_decode = 7'h78;
      4'h8: seg_decode = 7'h00;
      4'h9: seg_decode = 7'h10;
      4'hA: seg_decode = 7'h08;
      4'hB: seg_decode = 7'h03;
      4'hC: seg_decode = 7'h46;
      4'hD: seg_decode = 7'h21;
      4'hE: seg_decode = 7'h06;
      default: seg_decode = 7'h0E;
    endcase
  endfunction

  assign tick   = display_Freq & ~df_q;
  assign nibble = snap_data[{idx, 2'b00} +: 4];

  // A digit above 0 is blank when it and every more-significant active nibble is zero.
  always_comb begin
    suppress = 1'b0;
    if (LZ_BLANK && idx != 3'd0) begin
      suppress = 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (3'(i) >= idx && snap_data[4*i +: 4] != 4'h0) suppress = 1'b0;
      end
    end
  end

  // Next-state and next-output logic for the BLANK/SHOW scan.
  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    blank_cnt_nxt = blank_cnt;
    snap_load     = 1'b0;
    an_nxt        = 8'hFF;
    seg_nxt       = 7'h7F;
    dp_nxt        = 1'b1;
    fd_nxt        = 1'b0;
    case (state)
      BLANK: begin
        blank_cnt_nxt = blank_cnt + CW'(1);
        snap_load     = (idx == 3'd0) && (blank_cnt == '0);
        if (blank_cnt == BLANK_LAST) state_nxt = SHOW;
      end
      SHOW: begin
        an_nxt[idx] = ~snap_en[idx];
        seg_nxt     = suppress ? 7'h7F : seg_decode(nibble);
        dp_nxt      = ~snap_dp[idx];
        if (tick) begin
          state_nxt     = BLANK;
          blank_cnt_nxt = '0;
          if (idx == LAST_IDX) begin
            idx_nxt = 3'd0;
            fd_nxt  = 1'b1;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end
      end
      default: state_nxt = BLANK;
    endcase
  end

  // Scan state, digit index, blank counter and edge-detect history.
  always_ff @(posedge Sys_Clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= BLANK;
      idx       <= 3'd0;
      blank_cnt <= '0;
      df_q      <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      blank_cnt <= blank_cnt_nxt;
      df_q      <= display_Freq;
    end
  end

  // Per-frame snapshot of the value, enables and decimal points.
  always_ff @(posedge Sys_Clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_data <= 32'h0;
      snap_en   <= 8'h0;
      snap_dp   <= 8'h0;
    end else if (snap_load) begin
      snap_data <= data;
      snap_en   <= digit_en;
      snap_dp   <= dp_en;
    end
  end

  // Registered board outputs; reset forces the display dark immediately.
  always_ff @(posedge Sys_Clk or negedge rst_n) begin
    if (!rst_n) begin
      AN         <= 8'hFF;
      SEG        <= 7'h7F;
      DP         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      AN         <= an_nxt;
      SEG        <= seg_nxt;
      DP         <= dp_nxt;
      frame_done <= fd_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver. Two instances share all inputs: u0 uses the
// default parameters, u1 uses five digits, a short blanking gap and leading
// zero suppression. A timing model predicts outputs from elapsed cycles since
// the last accepted advance; a negedge compare process checks both instances
// every cycle, and directed literal checks pin the model.
module tb_seg7_scan_driver;

  localparam int N0 = 8, B0 = 16;
  localparam int N1 = 5, B1 = 4;
  localparam int W  = 17;
  localparam logic [W-1:0] DARK = {8'hFF, 7'h7F, 1'b1, 1'b0};

  logic        clk, rst_n, df;
  logic [31:0] data;
  logic [7:0]  digit_en, dp_en;
  logic [7:0]  an0, an1;
  logic [6:0]  seg0, seg1;
  logic        dp0, dp1, fd0, fd1;

  int n_checks = 0;
  int n_fail   = 0;
  int fd_cnt0  = 0;
  int fd_cnt1  = 0;

  logic [W-1:0] exp_q0[$];
  logic [W-1:0] exp_q1[$];

  logic [6:0]  dec_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int          since [2];
  int          midx  [2];
  logic [31:0] msnap [2];
  logic [7:0]  men   [2];
  logic [7:0]  mdp   [2];
  logic        prev_df;

  seg7_scan_driver #(.NUM_DIGITS(N0), .BLANK_CYCLES(B0), .LZ_BLANK(1'b0)) u0 (
    .Sys_Clk(clk), .rst_n(rst_n), .display_Freq(df), .data(data),
    .digit_en(digit_en), .dp_en(dp_en), .AN(an0), .SEG(seg0), .DP(dp0),
    .frame_done(fd0));

  seg7_scan_driver #(.NUM_DIGITS(N1), .BLANK_CYCLES(B1), .LZ_BLANK(1'b1)) u1 (
    .Sys_Clk(clk), .rst_n(rst_n), .display_Freq(df), .data(data),
    .digit_en(digit_en), .dp_en(dp_en), .AN(an1), .SEG(seg1), .DP(dp1),
    .frame_done(fd1));

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: after reset or an accepted advance the display is dark for the
  // blanking gap, then the digit is lit until a display_Freq rising edge.
  task automatic model_step(input int k, input logic tk);
    int nd, bc, d;
    logic lz;
    logic [7:0] an;
    logic [6:0] sg;
    logic dp, fd;
    logic [63:0] mask;
    logic [31:0] v;
    nd = (k == 0) ? N0 : N1;
    bc = (k == 0) ? B0 : B1;
    lz = (k == 1);
    an = 8'hFF; sg = 7'h7F; dp = 1'b1; fd = 1'b0;
    if (!rst_n) begin
      since[k] = 0; midx[k] = 0; msnap[k] = 0; men[k] = 0; mdp[k] = 0;
    end else begin
      d = since[k] + 1;
      if (d >= bc + 1) begin
        an[midx[k]] = ~men[k][midx[k]];
        mask = (64'd1 << (4 * nd)) - 64'd1;
        v = msnap[k] & mask[31:0];
        if (lz && midx[k] > 0 && (v >> (4 * midx[k])) == 0) sg = 7'h7F;
        else sg = dec_tbl[(msnap[k] >> (4 * midx[k])) & 32'hF];
        dp = ~mdp[k][midx[k]];
        if (tk) begin
          fd = (midx[k] == nd - 1);
          midx[k] = (midx[k] == nd - 1) ? 0 : midx[k] + 1;
          since[k] = 0;
        end else begin
          since[k] = bc + 1;
        end
      end else begin
        if (d == 1 && midx[k] == 0) begin
          msnap[k] = data; men[k] = digit_en; mdp[k] = dp_en;
        end
        since[k] = d;
      end
    end
    if (k == 0) exp_q0.push_back({an, sg, dp, fd});
    else        exp_q1.push_back({an, sg, dp, fd});
  endtask

  // Model advances on each active edge
  always @(posedge clk) begin
    logic tk;
    tk = df & ~prev_df;
    prev_df = rst_n ? df : 1'b0;
    model_step(0, tk);
    model_step(1, tk);
  end

  // Scoreboard compare on the inactive edge
  always @(negedge clk) begin
    logic [W-1:0] e0, e1;
    e0 = (exp_q0.size() > 0) ? exp_q0.pop_front() : DARK;
    e1 = (exp_q1.size() > 0) ? exp_q1.pop_front() : DARK;
    if (!rst_n) begin e0 = DARK; e1 = DARK; end
    check("an0", an0, e0[16:9]);
    check("seg0", seg0, e0[8:2]);
    check("dp0", dp0, e0[1]);
    check("fd0", fd0, e0[0]);
    check("an1", an1, e1[16:9]);
    check("seg1", seg1, e1[8:2]);
    check("dp1", dp1, e1[1]);
    check("fd1", fd1, e1[0]);
    if (fd0) fd_cnt0++;
    if (fd1) fd_cnt1++;
  end

  // Driver tasks
  task automatic pulse();
    @(negedge clk) df = 1'b1;
    repeat (11) @(negedge clk);
    df = 1'b0;
    repeat (11) @(negedge clk);
  endtask

  task automatic do_reset(input logic [31:0] d, input logic [7:0] en, input logic [7:0] dpv);
    @(posedge clk);
    #2 rst_n = 1'b0;
    data = d; digit_en = en; dp_en = dpv; df = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [7:0] an_tbl  [8] = '{8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F, 8'hFE};
  logic [6:0] seg_tbl [8] = '{7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h00};

  initial begin
    rst_n = 1'b0; df = 1'b0; prev_df = 1'b0;
    data = 32'h1234_5678; digit_en = 8'hFF; dp_en = 8'h00;
    repeat (3) @(negedge clk);
    #1 check("reset_an", an0, 8'hFF);
    check("reset_seg", seg0, 7'h7F);
    check("reset_fd", fd0, 1'b0);
    @(negedge clk) rst_n = 1'b1;

    // Blanking gap after reset, then digit 0
    repeat (B0) begin
      @(negedge clk);
      check("blank_an", an0, 8'hFF);
      check("blank_seg", seg0, 7'h7F);
    end
    @(negedge clk);
    check("first_an", an0, 8'hFE);
    check("first_seg", seg0, 7'h00);
    check("first_seg_u1", seg1, 7'h00);

    // Full frame
    fd_cnt0 = 0; fd_cnt1 = 0;
    for (int i = 0; i < 8; i++) begin
      pulse();
      check("frame_an", an0, an_tbl[i]);
      check("frame_seg", seg0, seg_tbl[i]);
    end
    check("frame_done_cnt0", fd_cnt0, 1);
    check("frame_done_cnt1", fd_cnt1, 1);

    // Data change mid-frame is held off until the next frame
    repeat (3) pulse();
    check("mid_an", an0, 8'hF7);
    check("mid_seg", seg0, 7'h12);
    data = 32'hFFFF_FFFF;
    repeat (4) pulse();
    check("old_d7_an", an0, 8'h7F);
    check("old_d7_seg", seg0, 7'h79);
    pulse();
    check("new_d0_an", an0, 8'hFE);
    check("new_d0_seg", seg0, 7'h0E);

    // Leading zeros, enables, decimal points
    do_reset(32'h0000_0A05, 8'h0F, 8'h02);
    repeat (B0 + 1) @(negedge clk);
    check("lz_d0_seg1", seg1, 7'h12);
    check("en_d0_dp0", dp0, 1'b1);
    pulse();
    check("lz_d1_seg1", seg1, 7'h40);
    check("dp_d1", dp0, 1'b0);
    check("dp_d1_u1", dp1, 1'b0);
    pulse();
    check("lz_d2_seg1", seg1, 7'h08);
    check("lz_d2_an1", an1, 8'hFB);
    pulse();
    check("lz_d3_an1", an1, 8'hF7);
    check("lz_d3_seg1", seg1, 7'h7F);
    check("nolz_d3_seg0", seg0, 7'h40);
    pulse();
    check("en_d4_an0", an0, 8'hFF);
    check("en_d4_an1", an1, 8'hFF);
    pulse();
    check("en_d5_an0", an0, 8'hFF);
    check("d5_seg0", seg0, 7'h40);

    // Asynchronous reset while digit 5 is lit
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_an0", an0, 8'hFF);
    check("async_seg0", seg0, 7'h7F);
    check("async_an1", an1, 8'hFF);
    data = 32'h1234_5678; digit_en = 8'hFF; dp_en = 8'h00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    df = 1'b1;
    repeat (40) @(negedge clk);
    check("restart_an0", an0, 8'hFE);
    check("restart_seg0", seg0, 7'h00);
    check("restart_an1", an1, 8'hFE);
    df = 1'b0;
    repeat (5) @(negedge clk);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
